// File: rtl/thread_scheduler_if.sv
// Control/issue bundle between the 4-thread pipeline front end and the thread scheduler.
// The master drives run control, branch and halt events; the slave drives issue and writeback IDs.
interface thread_scheduler_if #(
  parameter int unsigned PC_W = 9
);
  logic [3:0]      thread_en;
  logic            start;
  logic            stall;
  logic            br_taken;
  logic [1:0]      br_thread;
  logic [PC_W-1:0] br_target;
  logic            halt;
  logic [1:0]      halt_thread;
  logic            issue_valid;
  logic [1:0]      thread_rd;
  logic [PC_W-1:0] fetch_pc;
  logic            wr_valid;
  logic [1:0]      thread_wr;
  logic            busy;
  logic            done;

  modport master (
    output thread_en, start, stall, br_taken, br_thread, br_target, halt, halt_thread,
    input  issue_valid, thread_rd, fetch_pc, wr_valid, thread_wr, busy, done
  );

  modport slave (
    input  thread_en, start, stall, br_taken, br_thread, br_target, halt, halt_thread,
    output issue_valid, thread_rd, fetch_pc, wr_valid, thread_wr, busy, done
  );
endinterface

// File: rtl/thread_scheduler.sv
// Fine-grained round-robin issue for a 4-thread pipeline, with per-thread PCs and a
// writeback thread-ID delay line aligned to the issue stream.
module thread_scheduler #(
  parameter int unsigned PC_W     = 9,
  parameter int unsigned WB_LAT   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input logic               clk,
  input logic               clr,
  thread_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q [4];
  logic [PC_W-1:0] pc_d [4];
  logic [3:0]      halted_q, halted_d;
  logic [1:0]      rr_last_q, rr_last_d;
  logic            issue_valid_q, issue_valid_d;
  logic [1:0]      thread_rd_q, thread_rd_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WB_LAT-1:0] dl_valid_q;
  logic [1:0]        dl_id_q [WB_LAT];

  logic [3:0] halt_onehot, ready;
  logic [1:0] sel, idx;
  logic       found;

  // A thread retiring its halt this cycle is already out of the rotation.
  assign halt_onehot = bus.halt ? (4'b0001 << bus.halt_thread) : 4'b0000;
  assign ready       = bus.thread_en & ~halted_q & ~halt_onehot;

  always_comb begin
    sel   = rr_last_q;
    idx   = rr_last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_last_q + 2'(k);
      if (!found && ready[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halted_d      = halted_q;
    rr_last_d     = rr_last_q;
    issue_valid_d = issue_valid_q;
    thread_rd_d   = thread_rd_q;
    fetch_pc_d    = fetch_pc_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StRun;
          halted_d  = '0;
          rr_last_d = 2'd3;
          for (int t = 0; t < 4; t++) pc_d[t] = PC_W'(RESET_PC);
        end
      end
      StRun: begin
        if (!bus.stall) begin
          if (found) begin
            issue_valid_d = 1'b1;
            thread_rd_d   = sel;
            fetch_pc_d    = pc_q[sel];
            rr_last_d     = sel;
            pc_d[sel]     = pc_q[sel] + PC_W'(1);
          end else begin
            issue_valid_d = 1'b0;
            if (!issue_valid_q && (dl_valid_q == '0)) state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Redirect and halt bookkeeping apply even under stall; redirect beats the increment.
    if (bus.br_taken) pc_d[bus.br_thread] = bus.br_target;
    if (bus.halt) halted_d[bus.halt_thread] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StIdle;
      halted_q      <= '0;
      rr_last_q     <= 2'd3;
      issue_valid_q <= 1'b0;
      thread_rd_q   <= '0;
      fetch_pc_q    <= '0;
      dl_valid_q    <= '0;
      for (int t = 0; t < 4; t++) pc_q[t] <= PC_W'(RESET_PC);
      for (int k = 0; k < WB_LAT; k++) dl_id_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      rr_last_q     <= rr_last_d;
      issue_valid_q <= issue_valid_d;
      thread_rd_q   <= thread_rd_d;
      fetch_pc_q    <= fetch_pc_d;
      if (!bus.stall) begin
        // Outside RUN the line fills with zeros.
        dl_valid_q[0] <= (state_q == StRun) && issue_valid_q;
        dl_id_q[0]    <= (state_q == StRun) ? thread_rd_q : 2'd0;
        for (int k = 1; k < WB_LAT; k++) begin
          dl_valid_q[k] <= dl_valid_q[k-1];
          dl_id_q[k]    <= dl_id_q[k-1];
        end
      end
    end
  end

  assign bus.issue_valid = issue_valid_q;
  assign bus.thread_rd   = thread_rd_q;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.wr_valid    = dl_valid_q[WB_LAT-1];
  assign bus.thread_wr   = dl_id_q[WB_LAT-1];
  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed and randomized checks of thread_scheduler against a queue-based reference model.
module tb_thread_scheduler;
  localparam int unsigned PC_W   = 9;
  localparam int unsigned WB_LAT = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  thread_scheduler_if #(.PC_W(PC_W)) bus ();

  thread_scheduler #(.PC_W(PC_W), .WB_LAT(WB_LAT), .RESET_PC(0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 run, 2 done; writeback pipe is a queue, front is the output.
  int              m_state;
  logic [PC_W-1:0] m_pc [4];
  bit              m_halted [4];
  int              m_last;
  bit              m_iv;
  int              m_rd;
  logic [PC_W-1:0] m_fpc;
  bit              m_wv [$];
  int              m_wid [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_last  = 3;
    m_iv    = 0;
    m_rd    = 0;
    m_fpc   = '0;
    for (int i = 0; i < 4; i++) begin
      m_pc[i]     = '0;
      m_halted[i] = 0;
    end
    m_wv.delete();
    m_wid.delete();
    for (int i = 0; i < WB_LAT; i++) begin
      m_wv.push_back(0);
      m_wid.push_back(0);
    end
  endtask

  task automatic model_step();
    bit rdy [4];
    bit any;
    bit drained;
    int sel;
    if (clr) begin
      model_reset();
      return;
    end
    any = 0;
    sel = -1;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = bus.thread_en[i] && !m_halted[i] && !(bus.halt && (int'(bus.halt_thread) == i));
      if (rdy[i]) any = 1;
    end
    drained = !m_iv;
    foreach (m_wv[i]) if (m_wv[i]) drained = 0;
    if (!bus.stall) begin
      m_wv.push_back((m_state == 1) && m_iv);
      m_wid.push_back((m_state == 1) ? m_rd : 0);
      void'(m_wv.pop_front());
      void'(m_wid.pop_front());
    end
    if (m_state != 1 && bus.start) begin
      m_state = 1;
      m_last  = 3;
      for (int i = 0; i < 4; i++) begin
        m_pc[i]     = '0;
        m_halted[i] = 0;
      end
    end else if (m_state == 1 && !bus.stall) begin
      if (any) begin
        for (int k = 1; k <= 4; k++) if (sel < 0 && rdy[(m_last + k) % 4]) sel = (m_last + k) % 4;
        m_iv      = 1;
        m_rd      = sel;
        m_fpc     = m_pc[sel];
        m_last    = sel;
        m_pc[sel] = m_pc[sel] + 9'd1;
      end else begin
        m_iv = 0;
        if (drained) m_state = 2;
      end
    end
    if (bus.br_taken) m_pc[bus.br_thread] = bus.br_target;
    if (bus.halt) m_halted[bus.halt_thread] = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".issue_valid"}, 32'(bus.issue_valid), 32'(m_iv));
    chk({tag, ".thread_rd"},   32'(bus.thread_rd),   32'(m_rd));
    chk({tag, ".fetch_pc"},    32'(bus.fetch_pc),    32'(m_fpc));
    chk({tag, ".wr_valid"},    32'(bus.wr_valid),    32'(m_wv[0]));
    chk({tag, ".thread_wr"},   32'(bus.thread_wr),   32'(m_wid[0]));
    chk({tag, ".busy"},        32'(bus.busy),        32'(m_state == 1));
    chk({tag, ".done"},        32'(bus.done),        32'(m_state == 2));
  endtask

  // One clock: model consumes the current inputs, DUT samples them, pulses then drop.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    clr          = 1'b0;
    bus.start    = 1'b0;
    bus.br_taken = 1'b0;
    bus.halt     = 1'b0;
    check_all(tag);
  endtask

  initial begin
    bus.thread_en   = 4'b0000;
    bus.start       = 1'b0;
    bus.stall       = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_thread   = 2'd0;
    bus.br_target   = '0;
    bus.halt        = 1'b0;
    bus.halt_thread = 2'd0;
    model_reset();

    // Reset state.
    clr = 1'b1;
    step("reset");
    chk("reset.rd_zero", 32'(bus.thread_rd), 32'd0);
    step("idle");

    // All four threads rotate 0,1,2,3 with PCs advancing once per round.
    bus.thread_en = 4'b1111;
    bus.start = 1'b1;
    step("t1.start");
    for (int j = 0; j < 6; j++) begin
      step("t1.run");
      chk("t1.seq_rd", 32'(bus.thread_rd), 32'(j % 4));
      chk("t1.seq_pc", 32'(bus.fetch_pc), 32'(j / 4));
    end
    for (int j = 0; j < WB_LAT; j++) step("t1.wb");

    // Only threads 0 and 2 enabled.
    clr = 1'b1;
    step("t2.clr");
    bus.thread_en = 4'b0101;
    bus.start = 1'b1;
    step("t2.start");
    for (int j = 0; j < 4; j++) begin
      step("t2.run");
      chk("t2.seq_rd", 32'(bus.thread_rd), 32'((j % 2) * 2));
      chk("t2.seq_pc", 32'(bus.fetch_pc), 32'(j / 2));
    end

    // Redirect thread 1 on the edge that selects it.
    clr = 1'b1;
    step("t3.clr");
    bus.thread_en = 4'b1111;
    bus.start = 1'b1;
    step("t3.start");
    step("t3.sel0");
    bus.br_taken  = 1'b1;
    bus.br_thread = 2'd1;
    bus.br_target = 9'h040;
    step("t3.br");
    chk("t3.old_pc", 32'(bus.fetch_pc), 32'd0);
    for (int j = 0; j < 4; j++) step("t3.run");
    chk("t3.target_rd", 32'(bus.thread_rd), 32'd1);
    chk("t3.target_pc", 32'(bus.fetch_pc), 32'h40);
    for (int j = 0; j < 4; j++) step("t3.run2");
    chk("t3.target_pc1", 32'(bus.fetch_pc), 32'h41);

    // Stall for three cycles mid-run.
    bus.stall = 1'b1;
    for (int j = 0; j < 3; j++) step("t4.stall");
    bus.stall = 1'b0;
    for (int j = 0; j < 6; j++) step("t4.resume");

    // Halt 3,2,1,0 in turn, then drain to DONE and restart.
    for (int t = 3; t >= 0; t--) begin
      bus.halt        = 1'b1;
      bus.halt_thread = 2'(t);
      step("t5.halt");
      step("t5.run");
      step("t5.run");
    end
    for (int j = 0; j < 40 && m_state != 2; j++) step("t5.drain");
    chk("t5.done", 32'(bus.done), 32'd1);
    step("t5.hold");
    chk("t5.done_hold", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    step("t5.restart");
    step("t5.first");
    chk("t5.first_rd", 32'(bus.thread_rd), 32'd0);
    chk("t5.first_pc", 32'(bus.fetch_pc), 32'd0);
    chk("t5.first_iv", 32'(bus.issue_valid), 32'd1);

    // Clear mid-run while stalled.
    for (int j = 0; j < 5; j++) step("t6.run");
    bus.stall = 1'b1;
    clr = 1'b1;
    step("t6.clr");
    chk("t6.busy", 32'(bus.busy), 32'd0);
    chk("t6.wr_valid", 32'(bus.wr_valid), 32'd0);
    bus.stall = 1'b0;
    for (int j = 0; j < WB_LAT + 1; j++) step("t6.idle");

    // Randomized traffic.
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(0, 49) == 0) bus.thread_en = 4'($urandom_range(0, 15));
      bus.start       = ($urandom_range(0, 19) == 0);
      bus.stall       = ($urandom_range(0, 4) == 0);
      bus.br_taken    = ($urandom_range(0, 9) == 0);
      bus.br_thread   = 2'($urandom_range(0, 3));
      bus.br_target   = 9'($urandom_range(0, 511));
      bus.halt        = ($urandom_range(0, 24) == 0);
      bus.halt_thread = 2'($urandom_range(0, 3));
      clr             = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
